mem_arb: RTL and testbench
==========================

# mem_arb

Single-port RAM arbiter for byteblast8. It shares the one RAM between two requesters: the instruction-fetch path (pc address, read-only) and the execute-stage data path (load/store). Each cycle it grants at most one requester and drives the RAM address, write-enable and write-data from the winner. It returns a read-valid strobe to the owner of each read one cycle later, and a burst limit stops the data path from starving fetch.

## Interface
- ADDR_W, 6, RAM address width (matches pc width)
- DATA_W, 8, RAM data width
- MAX_BURST, 4, max consecutive data grants while fetch is requesting (1..15)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request, level, held until granted
- f_adr  in  ADDR_W  fetch address (pc crnt_adr)
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  rdata holds the fetch word (registered)
- d_req  in  1  data request, level, held until granted
- d_we  in  1  1 = write, 0 = read
- d_adr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  rdata holds the data-read word (registered; never set for writes)
- rdata  out  DATA_W  shared read data, passthrough of ram_rdata
- ram_we  out  1  RAM write enable
- ram_adr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM synchronous read data, valid one cycle after the address

## Operation
- Owner state register `own` has three values: IDLE (no grant last cycle), FETCH, DATA. It updates every posedge to the current grant.
- burst_cnt (4 bits) counts consecutive DATA grants. It increments on each d_gnt, saturates at MAX_BURST, and clears on any cycle without d_gnt.
- Grant decision (combinational, one-hot or none):
  - only f_req → f_gnt; only d_req → d_gnt; neither → none.
  - both, own=IDLE → fetch wins.
  - both, own=FETCH → data wins.
  - both, own=DATA, burst_cnt < MAX_BURST → data wins; otherwise fetch wins.
- Mux: winner's adr, we and wdata drive ram_adr, ram_we and ram_wdata; f_gnt forces ram_we=0.
- No grant → ram_we=0, ram_adr=0, ram_wdata=0.
- Read return: f_rvalid <= f_gnt; d_rvalid <= d_gnt & ~d_we. At most one is high per cycle.
- A requester drops or changes its request only after seeing its gnt. A request with no gnt is ignored without side effects.

## Timing
- Reset low (async): own=IDLE, burst_cnt=0, f_rvalid=0, d_rvalid=0 immediately. f_gnt, d_gnt and ram_we are forced 0 while reset is low.
- Reset in the middle of a read: the pending rvalid is lost, and the requester must re-request.
- Grant latency: 0 cycles (same cycle as req when the arbiter is free to grant).
- Read latency: rvalid and rdata arrive 1 cycle after gnt. A write completes at the posedge ending the gnt cycle.
- Back-to-back grants are allowed every cycle. Sustained contention with MAX_BURST=4 gives the pattern D,D,D,D,F,D,D,D,D,F... after an initial F.
- With fetch idle, data is never throttled. burst_cnt saturates and does not wrap.
- Address wrap is the requester's concern. The arbiter passes ADDR_W bits unmodified.

## Test plan
- Reset with f_req=1, d_req=1 and reset low → f_gnt=d_gnt=ram_we=0 and both rvalids 0. After release, the first cycle grants fetch (own=IDLE).
- Fetch only: RAM[0..3]=1,2,3,4, f_req=1, f_adr 0,1,2,3 → f_gnt every cycle. f_rvalid on cycles 1–4 with rdata 1,2,3,4.
- Data write then read: d_we=1, d_adr=5, d_wdata=0xA5, one cycle; then d_we=0, d_adr=5 → ram_we pulses once, and the next cycle d_rvalid=1 with rdata=0xA5. No d_rvalid for the write.
- Contention, MAX_BURST=4, both req held for 12 cycles → grant sequence F,D,D,D,D,F,D,D,D,D,F,D.
- Alternation: both req, data releasing after each grant and re-asserting → F,D,F,D… with burst_cnt ≤1.
- Async reset asserted mid-read (between gnt and rvalid edge) → f_rvalid stays 0, own=IDLE, burst_cnt=0.

Source files
------------

// File: rtl/mem_arb.sv
// Single-port RAM arbiter: shares one synchronous RAM between instruction fetch
// and the execute-stage data path, with a burst limit so data cannot starve fetch.
module mem_arb #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_adr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } own_t;

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  own_t       r_own;
  logic [3:0] r_burst;
  logic       r_fRvalid;
  logic       r_dRvalid;
  logic       w_fGnt;
  logic       w_dGnt;
  logic       w_dataWinsTie;

  // Contention only: fetch wins after idle, data wins after fetch, and data
  // keeps the RAM until its burst count reaches the limit.
  always_comb begin
    w_dataWinsTie = 1'b0;
    case (r_own)
      OWN_FETCH: w_dataWinsTie = 1'b1;
      OWN_DATA:  w_dataWinsTie = (r_burst < LP_MAX_BURST);
      default:   w_dataWinsTie = 1'b0;
    endcase
  end

  always_comb begin
    w_fGnt = 1'b0;
    w_dGnt = 1'b0;
    if (reset) begin
      if (f_req && d_req) begin
        w_fGnt = ~w_dataWinsTie;
        w_dGnt = w_dataWinsTie;
      end else begin
        w_fGnt = f_req;
        w_dGnt = d_req;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_adr   = '0;
    ram_wdata = '0;
    if (w_fGnt) begin
      ram_adr = f_adr;
    end else if (w_dGnt) begin
      ram_we    = d_we;
      ram_adr   = d_adr;
      ram_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_own     <= OWN_IDLE;
      r_burst   <= 4'd0;
      r_fRvalid <= 1'b0;
      r_dRvalid <= 1'b0;
    end else begin
      if (w_fGnt) begin
        r_own <= OWN_FETCH;
      end else if (w_dGnt) begin
        r_own <= OWN_DATA;
      end else begin
        r_own <= OWN_IDLE;
      end
      // Saturate rather than wrap so a long data-only run still yields to fetch.
      if (!w_dGnt) begin
        r_burst <= 4'd0;
      end else if (r_burst < LP_MAX_BURST) begin
        r_burst <= r_burst + 4'd1;
      end
      r_fRvalid <= w_fGnt;
      r_dRvalid <= w_dGnt & ~d_we;
    end
  end

  assign f_gnt    = w_fGnt;
  assign d_gnt    = w_dGnt;
  assign f_rvalid = r_fRvalid;
  assign d_rvalid = r_dRvalid;
  assign rdata    = ram_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small synchronous RAM model attached
// to the RAM-side ports; expected values are hand-computed per vector.
module tb_mem_arb;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req;
  logic [ADDR_W-1:0] f_adr;
  logic              f_gnt;
  logic              f_rvalid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int vectorCount = 0;
  int missCount   = 0;

  mem_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_adr(f_adr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr] <= ram_wdata;
    ram_rdata <= mem[ram_adr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle's request inputs at the falling edge, then let
  // combinational grants settle before anything is sampled.
  task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa,
                               input logic dr, input logic dw,
                               input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] dd);
    @(negedge clk);
    f_req = fr; f_adr = fa;
    d_req = dr; d_we = dw; d_adr = da; d_wdata = dd;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] grantCode(input byte who);
    return (who == "F") ? 2'b10 : (who == "D") ? 2'b01 : 2'b00;
  endfunction

  string contention = "FDDDDFDDDDFD";
  string alternate  = "FDFDFD";
  logic  prevF;
  logic  prevDRead;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
    mem[63] = 8'h5A;
    ram_rdata = '0;

    // Reset held low with both requesting: everything forced quiet.
    reset = 1'b0;
    f_req = 1'b1; f_adr = 6'd0;
    d_req = 1'b1; d_we = 1'b0; d_adr = 6'd63; d_wdata = '0;
    #2;
    checkOutput("rst_f_gnt", 32'(f_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    stepEdge();
    checkOutput("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_grant", 32'({f_gnt, d_gnt}), 32'(2'b10));
    checkOutput("post_rst_adr", 32'(ram_adr), 32'd0);
    stepEdge();
    checkOutput("post_rst_f_rvalid", 32'(f_rvalid), 32'd1);
    checkOutput("post_rst_rdata", 32'(rdata), 32'd1);

    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 6'd63, 8'd0);
    checkOutput("post_rst_d_grant", 32'({f_gnt, d_gnt}), 32'(2'b01));
    stepEdge();
    checkOutput("post_rst_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("post_rst_d_rdata", 32'(rdata), 32'h5A);

    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    checkOutput("idle_grant", 32'({f_gnt, d_gnt}), 32'd0);
    checkOutput("idle_ram_we", 32'(ram_we), 32'd0);
    stepEdge();
    checkOutput("idle_rvalids", 32'({f_rvalid, d_rvalid}), 32'd0);

    // Fetch-only stream from RAM[0..3].
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 6'(i), 1'b0, 1'b0, 6'd0, 8'd0);
      checkOutput($sformatf("fetch%0d_gnt", i), 32'(f_gnt), 32'd1);
      checkOutput($sformatf("fetch%0d_adr", i), 32'(ram_adr), 32'(i));
      checkOutput($sformatf("fetch%0d_we", i), 32'(ram_we), 32'd0);
      stepEdge();
      checkOutput($sformatf("fetch%0d_rvalid", i), 32'({f_rvalid, d_rvalid}), 32'(2'b10));
      checkOutput($sformatf("fetch%0d_rdata", i), 32'(rdata), 32'(i + 1));
    end

    // Data write then read back of the same word.
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, 6'd5, 8'hA5);
    checkOutput("wr_gnt", 32'(d_gnt), 32'd1);
    checkOutput("wr_ram_we", 32'(ram_we), 32'd1);
    checkOutput("wr_ram_adr", 32'(ram_adr), 32'd5);
    checkOutput("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    stepEdge();
    checkOutput("wr_no_rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 6'd5, 8'h00);
    checkOutput("rd_gnt", 32'(d_gnt), 32'd1);
    checkOutput("rd_ram_we", 32'(ram_we), 32'd0);
    stepEdge();
    checkOutput("rd_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("rd_rdata", 32'(rdata), 32'hA5);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    stepEdge();
    checkOutput("rd_rvalid_clear", 32'(d_rvalid), 32'd0);

    // Sustained contention from idle owner.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 6'd1, 1'b1, 1'b0, 6'd5, 8'd0);
      checkOutput($sformatf("cont%0d", i), 32'({f_gnt, d_gnt}),
                  32'(grantCode(contention[i])));
      prevF = (contention[i] == "F");
      stepEdge();
      checkOutput($sformatf("cont%0d_rv", i), 32'({f_rvalid, d_rvalid}),
                  32'({prevF, ~prevF}));
    end
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    stepEdge();

    // Long data-only run: never throttled, burst count saturates without wrapping.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 6'd5, 8'd0);
      checkOutput($sformatf("dlong%0d", i), 32'({f_gnt, d_gnt}), 32'(2'b01));
      stepEdge();
    end
    checkOutput("dlong_rdata", 32'(rdata), 32'hA5);
    applyStimulus(1'b1, 6'd2, 1'b1, 1'b0, 6'd5, 8'd0);
    checkOutput("dlong_then_fetch", 32'({f_gnt, d_gnt}), 32'(2'b10));
    stepEdge();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    stepEdge();

    // Alternation: data drops for one cycle after every grant.
    prevDRead = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 6'd3, (i % 2 == 1) || (i == 0), 1'b0, 6'd5, 8'd0);
      checkOutput($sformatf("alt%0d", i), 32'({f_gnt, d_gnt}),
                  32'(grantCode(alternate[i])));
      stepEdge();
    end
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    stepEdge();

    // Async reset between a fetch grant and its rvalid edge.
    applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 6'd0, 8'd0);
    checkOutput("midrd_gnt", 32'(f_gnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrd_gnt_forced", 32'({f_gnt, d_gnt, ram_we}), 32'd0);
    stepEdge();
    checkOutput("midrd_rvalid_lost", 32'({f_rvalid, d_rvalid}), 32'd0);
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_adr = 6'd5;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrd_own_idle", 32'({f_gnt, d_gnt}), 32'(2'b10));
    stepEdge();
    checkOutput("midrd_refetch", 32'(rdata), 32'd3);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
